// File: rtl/register_file_lvt.sv
// Multi-write-port register file: one bank per commit port, a live-value
// table selecting the newest bank, an inflight scoreboard and a clear sweep.
module register_file_lvt #(
    parameter int WRITE_PORTS    = 2,
    parameter int READ_PORTS     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 64,
    parameter int ALLOW_WRITE_P0 = 0,
    parameter int BYPASS         = 1,
    localparam int AW            = $clog2(DEPTH),
    localparam int LW            = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear_req,
    output logic                                   ready,
    input  logic                                   alloc_valid,
    input  logic [AW-1:0]                          alloc_addr,
    input  logic [WRITE_PORTS-1:0]                 wr_valid,
    input  logic [WRITE_PORTS-1:0][AW-1:0]         wr_addr,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] wr_data,
    input  logic [READ_PORTS-1:0]                  rd_en,
    input  logic [READ_PORTS-1:0][AW-1:0]          rd_addr,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
    output logic [READ_PORTS-1:0]                  rd_inuse
);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                                 state_q, state_d;
    logic [AW-1:0]                          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]                  bank_q [WRITE_PORTS][DEPTH];
    logic [DEPTH-1:0]                       inuse_q;
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [READ_PORTS-1:0]                  rd_inuse_q, rd_inuse_d;
    logic [LW-1:0]                          lvt_rd [READ_PORTS];
    logic [WRITE_PORTS-1:0]                 wr_ok;
    logic                                   alloc_ok;
    logic [READ_PORTS-1:0]                  wr_hit, al_hit;
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  byp_data;

    // Entry 0 silently drops writes and allocations when hard-wired to zero
    always_comb begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
            wr_ok[p] = wr_valid[p] && (ALLOW_WRITE_P0 != 0 || wr_addr[p] != '0);
        end
        alloc_ok = alloc_valid && (ALLOW_WRITE_P0 != 0 || alloc_addr != '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_inuse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == RUN && !clear_req) begin
                for (int r = 0; r < READ_PORTS; r++) begin
                    if (rd_en[r]) begin
                        rd_data_q[r]  <= rd_data_d[r];
                        rd_inuse_q[r] <= rd_inuse_d[r];
                    end
                end
            end else begin
                rd_data_q  <= '0;
                rd_inuse_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (state_q == CLEAR) begin
                    bank_q[p][cnt_q] <= '0;
                end else if (wr_ok[p]) begin
                    bank_q[p][wr_addr[p]] <= wr_data[p];
                end
            end
        end
    end

    // Allocation is applied last so a new producer beats a same-cycle commit
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == CLEAR) begin
                inuse_q[cnt_q] <= 1'b0;
            end else begin
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (wr_ok[p]) begin
                        inuse_q[wr_addr[p]] <= 1'b0;
                    end
                end
                if (alloc_ok) begin
                    inuse_q[alloc_addr] <= 1'b1;
                end
            end
        end
    end

    if (WRITE_PORTS > 1) begin : g_lvt
        logic [LW-1:0] lvt_q [DEPTH];

        always_ff @(posedge clk) begin
            if (rst_n) begin
                if (state_q == CLEAR) begin
                    lvt_q[cnt_q] <= '0;
                end else begin
                    for (int p = 0; p < WRITE_PORTS; p++) begin
                        if (wr_ok[p]) begin
                            lvt_q[wr_addr[p]] <= LW'(p);
                        end
                    end
                end
            end
        end

        always_comb begin
            for (int r = 0; r < READ_PORTS; r++) begin
                lvt_rd[r] = lvt_q[rd_addr[r]];
            end
        end
    end else begin : g_no_lvt
        always_comb begin
            for (int r = 0; r < READ_PORTS; r++) begin
                lvt_rd[r] = '0;
            end
        end
    end

    always_comb begin
        wr_hit     = '0;
        al_hit     = '0;
        byp_data   = '0;
        rd_data_d  = '0;
        rd_inuse_d = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (wr_ok[p] && wr_addr[p] == rd_addr[r]) begin
                    wr_hit[r]   = 1'b1;
                    byp_data[r] = wr_data[p];
                end
            end
            al_hit[r]     = alloc_ok && (alloc_addr == rd_addr[r]);
            rd_data_d[r]  = bank_q[lvt_rd[r]][rd_addr[r]];
            rd_inuse_d[r] = inuse_q[rd_addr[r]];
            if (BYPASS != 0) begin
                if (wr_hit[r]) begin
                    rd_data_d[r] = byp_data[r];
                end
                rd_inuse_d[r] = al_hit[r] | (inuse_q[rd_addr[r]] & ~wr_hit[r]);
            end
            if (ALLOW_WRITE_P0 == 0 && rd_addr[r] == '0) begin
                rd_data_d[r]  = '0;
                rd_inuse_d[r] = 1'b0;
            end
        end
    end

    assign ready    = (state_q == RUN);
    assign rd_data  = rd_data_q;
    assign rd_inuse = rd_inuse_q;

endmodule

// File: tb/tb_register_file_lvt.sv
// Bench for register_file_lvt: directed literal cases plus random traffic
// compared every cycle against an architectural model of the file.
module tb_register_file_lvt;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear_req;
    logic             ready;
    logic             alloc_valid;
    logic [5:0]       alloc_addr;
    logic [1:0]       wr_valid;
    logic [1:0][5:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic [1:0]       rd_en;
    logic [1:0][5:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_inuse;

    int checks = 0;
    int errors = 0;

    register_file_lvt #(
        .WRITE_PORTS(2), .READ_PORTS(2), .DATA_WIDTH(32), .DEPTH(64),
        .ALLOW_WRITE_P0(0), .BYPASS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_inuse(rd_inuse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural model: value of each register and its inflight bit
    logic [31:0] m_mem [64];
    bit          m_inuse [64];
    int          sweep_left = 0;
    bit          mvalid = 0;
    bit          e_ready = 0;
    logic [31:0] e_data [2];
    bit          e_inuse [2];

    always @(posedge clk) begin : model
        logic [31:0] nm [64];
        bit          ni [64];
        int          a;
        if (!rst_n || (sweep_left == 0 && clear_req)) begin
            mvalid = 1;
            sweep_left = 64;
            e_ready = 0;
            for (int i = 0; i < 64; i++) begin
                m_mem[i] = 0;
                m_inuse[i] = 0;
            end
            for (int r = 0; r < 2; r++) begin
                e_data[r] = 0;
                e_inuse[r] = 0;
            end
        end else if (sweep_left > 0) begin
            sweep_left--;
            e_ready = (sweep_left == 0);
        end else begin
            nm = m_mem;
            ni = m_inuse;
            for (int p = 0; p < 2; p++) begin
                if (wr_valid[p] && wr_addr[p] != 0) begin
                    nm[wr_addr[p]] = wr_data[p];
                    ni[wr_addr[p]] = 0;
                end
            end
            if (alloc_valid && alloc_addr != 0) ni[alloc_addr] = 1;
            for (int r = 0; r < 2; r++) begin
                if (rd_en[r]) begin
                    a = int'(rd_addr[r]);
                    e_data[r] = nm[a];
                    e_inuse[r] = ni[a];
                end
            end
            m_mem = nm;
            m_inuse = ni;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("ready", 32'(ready), 32'(e_ready));
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("model_rd_data%0d", r), rd_data[r], e_data[r]);
                chk($sformatf("model_rd_inuse%0d", r), 32'(rd_inuse[r]),
                    32'(e_inuse[r]));
            end
        end
    end

    task automatic idle();
        clear_req = 0;
        alloc_valid = 0;
        alloc_addr = 0;
        wr_valid = 0;
        wr_addr = '0;
        wr_data = '0;
        rd_en = 0;
        rd_addr = '0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic commit(input int p, input int a, input logic [31:0] d);
        wr_valid[p] = 1'b1;
        wr_addr[p] = 6'(a);
        wr_data[p] = d;
    endtask

    task automatic rd(input int r, input int a);
        rd_en[r] = 1'b1;
        rd_addr[r] = 6'(a);
    endtask

    task automatic alloc(input int a);
        alloc_valid = 1'b1;
        alloc_addr = 6'(a);
    endtask

    task automatic expect_rd(input string nm, input int r,
                             input logic [31:0] d, input logic u);
        chk({nm, "_data"}, rd_data[r], d);
        chk({nm, "_inuse"}, 32'(rd_inuse[r]), 32'(u));
    endtask

    task automatic wait_ready(input string nm, input int exp_edges);
        int n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        chk(nm, n, exp_edges);
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        wait_ready("reset_sweep_edges", 64);

        for (int a = 0; a < 64; a++) begin
            rd(0, a);
            rd(1, 63 - a);
            step();
            expect_rd("post_reset_p0", 0, 32'h0, 1'b0);
            expect_rd("post_reset_p1", 1, 32'h0, 1'b0);
        end

        commit(1, 5, 32'hDEADBEEF);
        rd(0, 5);
        step();
        expect_rd("bypass_p1", 0, 32'hDEADBEEF, 1'b0);
        commit(0, 5, 32'h12345678);
        rd(1, 5);
        step();
        expect_rd("bypass_p0", 1, 32'h12345678, 1'b0);
        rd(0, 5);
        rd(1, 5);
        step();
        expect_rd("lvt_r0", 0, 32'h12345678, 1'b0);
        expect_rd("lvt_r1", 1, 32'h12345678, 1'b0);

        alloc(7);
        rd(0, 7);
        step();
        expect_rd("alloc_n0", 0, 32'h0, 1'b1);
        rd(0, 7);
        step();
        expect_rd("alloc_n1", 0, 32'h0, 1'b1);
        rd(1, 7);
        step();
        expect_rd("alloc_n2", 1, 32'h0, 1'b1);
        commit(1, 7, 32'hA5A50007);
        rd(0, 7);
        step();
        expect_rd("commit_n3", 0, 32'hA5A50007, 1'b0);

        alloc(9);
        commit(0, 9, 32'h00000099);
        step();
        rd(1, 9);
        step();
        expect_rd("alloc_commit_9", 1, 32'h00000099, 1'b1);

        alloc(0);
        commit(0, 0, 32'h000000FF);
        rd(1, 0);
        step();
        expect_rd("zero_bypass", 1, 32'h0, 1'b0);
        rd(0, 0);
        step();
        expect_rd("zero_read", 0, 32'h0, 1'b0);

        commit(0, 3, 32'h33333333);
        commit(1, 60, 32'h60606060);
        step();
        rd(0, 3);
        rd(1, 60);
        step();
        expect_rd("pre_clear_3", 0, 32'h33333333, 1'b0);
        expect_rd("pre_clear_60", 1, 32'h60606060, 1'b0);
        clear_req = 1;
        step();
        begin
            int n = 0;
            while (!ready && n < 200) begin
                commit(0, 3, 32'hBAD00003);
                alloc(60);
                rd(0, 3);
                step();
                n++;
            end
            chk("clear_sweep_edges", n, 64);
        end
        rd(0, 3);
        rd(1, 60);
        step();
        expect_rd("post_clear_3", 0, 32'h0, 1'b0);
        expect_rd("post_clear_60", 1, 32'h0, 1'b0);

        clear_req = 1;
        step();
        repeat (30) step();
        chk("mid_sweep_ready", 32'(ready), 32'h0);
        rst_n = 0;
        step();
        rst_n = 1;
        wait_ready("restart_sweep_edges", 64);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            clear_req = ($urandom_range(0, 299) == 0);
            alloc_valid = $urandom_range(0, 2) == 0;
            alloc_addr = 6'($urandom_range(0, 15));
            for (int p = 0; p < 2; p++) begin
                wr_valid[p] = $urandom_range(0, 1) == 1;
                wr_addr[p] = ($urandom_range(0, 7) == 0)
                           ? 6'($urandom_range(0, 63))
                           : 6'($urandom_range(0, 15));
                wr_data[p] = $urandom;
            end
            for (int r = 0; r < 2; r++) begin
                rd_en[r] = $urandom_range(0, 3) != 0;
                rd_addr[r] = 6'($urandom_range(0, 15));
            end
            step();
        end
        rst_n = 1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_lvt.md
# register_file_lvt

Multi-write-port physical register file for CVA5 GP and FP register files: DATA_WIDTH-wide, DEPTH entries, WRITE_PORTS commit ports, READ_PORTS issue read ports. A live-value table (LVT) tracks which bank last wrote each entry, so issue no longer supplies a writeback-group per operand. An integrated inflight scoreboard is set on allocation and cleared on commit. A self-timed clear sweep zeroes data, LVT and scoreboard after reset or on request. It sits between decode/issue and the writeback commit ports.

## Interface
- WRITE_PORTS, 2: commit ports, ≥1; one register bank per port
- READ_PORTS, 2: read ports
- DATA_WIDTH, 32: entry width
- DEPTH, 64: entries, power of two; AW = $clog2(DEPTH)
- ALLOW_WRITE_P0, 0: 0 makes entry 0 hard-wired zero and never inflight
- BYPASS, 1: 1 forwards same-cycle commit data to reads
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- clear_req  in  1  restart clear sweep, sampled only when ready=1
- ready  out  1  sweep done, normal operation
- alloc_valid  in  1  mark alloc_addr inflight
- alloc_addr  in  AW  destination being allocated
- wr_valid  in  [WRITE_PORTS]  commit strobe per port
- wr_addr  in  [WRITE_PORTS][AW]  commit address
- wr_data  in  [WRITE_PORTS][DATA_WIDTH]  commit data
- rd_en  in  [READ_PORTS]  read request; outputs hold when low
- rd_addr  in  [READ_PORTS][AW]  read address
- rd_data  out  [READ_PORTS][DATA_WIDTH]  registered read data
- rd_inuse  out  [READ_PORTS]  registered inflight status of rd_addr

## Operation
- States: CLEAR, RUN. rst_n=0 forces CLEAR with sweep counter=0, ready=0, rd_data=0, rd_inuse=0.
- CLEAR, each cycle with rst_n=1:
  - write zero to entry[counter] in every bank; LVT[counter]=0; inuse[counter]=0
  - increment counter; after handling entry DEPTH-1, go to RUN with ready=1
  - alloc_valid, wr_valid and rd_en are ignored; rd outputs hold 0
- RUN: clear_req=1 goes to CLEAR with counter=0 and ready=0 next cycle. Contents are stale until the sweep finishes.
- Commit on port p (wr_valid[p]):
  - bank p entry wr_addr[p] <= wr_data[p]
  - LVT[wr_addr[p]] <= p
  - inuse[wr_addr[p]] <= 0
- Same address committed on several ports in one cycle is illegal. The highest port index wins LVT and bypass (defined, not asserted).
- Allocation: inuse[alloc_addr] <= 1. Allocation and commit to the same address in one cycle leave inuse=1 (new producer wins).
- Entry 0 with ALLOW_WRITE_P0=0:
  - commits and allocations to entry 0 are dropped
  - reads of entry 0 return 0 with rd_inuse=0
- Read port r with rd_en[r]=1, update on next edge:
  - if BYPASS=1 and some wr_valid[p] has wr_addr[p]==rd_addr[r]: rd_data[r] <= wr_data[p]
  - otherwise rd_data[r] <= bank[LVT[rd_addr[r]]][rd_addr[r]]
  - rd_inuse[r] <= post-update inuse bit, i.e. after that cycle's allocation/commit rules
- BYPASS=0: reads return pre-write contents and pre-update inuse.
- Storage: one bank per write port, each with READ_PORTS read ports. LVT is DEPTH × $clog2(WRITE_PORTS) flops, 0 bits wide when WRITE_PORTS=1.

## Timing
- ready rises at the DEPTH-th rising edge with rst_n=1 after reset release, or after clear_req is accepted.
- Read latency 1 cycle: rd_addr/rd_en sampled at edge N, rd_data/rd_inuse valid after edge N.
- A commit at edge N is visible to non-bypassed reads sampled at edge N+1 and later.
- Scoreboard updates take effect at the edge. Allocation at N gives rd_inuse=1 for reads sampled at N (post-update) and later.
- rst_n=0 mid-sweep or mid-RUN: next edge is CLEAR with counter=0. Pending commits are discarded.
- No backpressure. Every accepted commit or allocation completes in one cycle.

## Test plan
- Reset, DEPTH=64: rst_n low 2 cycles then high -> ready=0 for 63 edges, ready=1 at 64th edge. All 64 entries then read 0 with rd_inuse=0.
- Commit 0xDEADBEEF to entry 5 on port 1, then 0x12345678 to entry 5 on port 0 a cycle later -> read of 5 returns 0x12345678, LVT[5]=0.
- alloc 7 at cycle N, commit 7 on port 1 at N+3 with a read of 7 at N+3 -> rd_inuse=1 for reads at N..N+2. Read at N+3 gives rd_data=commit data (BYPASS=1) and rd_inuse=0.
- Allocate and commit entry 9 in the same cycle -> inuse[9]=1 afterwards. Commit 0xFF to entry 0 with ALLOW_WRITE_P0=0 -> entry 0 reads 0.
- clear_req in RUN after data written to entries 3 and 60 -> ready low 64 cycles, writes during sweep ignored, entries read 0 afterwards.
- rst_n low at sweep counter 30 -> sweep restarts at 0; ready rises exactly 64 edges after release.
